// File: rtl/mips_run_monitor.sv
// Run sequencer and completion monitor for MIPS_Core: holds the core in reset, releases it,
// watches for the terminating syscall or a cycle timeout, and keeps a circular PC trace.
module mips_run_monitor #(
    parameter int unsigned RST_HOLD_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned TRACE_DEPTH     = 8,
    parameter logic [31:0] SYSCALL_WORD    = 32'h0000000C,
    localparam int unsigned IDX_W          = $clog2(TRACE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      pc,
    input  logic [31:0]      inst,
    input  logic [31:0]      v0,
    input  logic [IDX_W-1:0] trace_idx,
    output logic             core_rst,
    output logic [2:0]       state,
    output logic             halted,
    output logic             timed_out,
    output logic [31:0]      cycle_cnt,
    output logic [31:0]      result,
    output logic [31:0]      halt_pc,
    output logic [31:0]      trace_pc,
    output logic [IDX_W:0]   trace_count
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES < 2) ? 1 : $clog2(RST_HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       halt_pc_q, halt_pc_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]    count_q, count_d;
    logic              core_rst_q, core_rst_d;
    logic              trace_we;
    logic [31:0]       trace_pc_q;
    logic [IDX_W-1:0]  rd_addr;

    logic [31:0]       trace_mem [TRACE_DEPTH];

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        result_d  = result_q;
        halt_pc_d = halt_pc_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        trace_we  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    cycle_d   = '0;
                    count_d   = '0;
                    wr_ptr_d  = '0;
                    result_d  = '0;
                    halt_pc_d = '0;
                    hold_d    = HOLD_W'(RST_HOLD_CYCLES);
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                hold_d = hold_q - HOLD_W'(1);
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                trace_we = 1'b1;
                wr_ptr_d = wr_ptr_q + IDX_W'(1);
                if (count_q != (IDX_W+1)'(TRACE_DEPTH)) begin
                    count_d = count_q + (IDX_W+1)'(1);
                end
                cycle_d = cycle_q + 32'd1;
                // Syscall wins over a timeout landing on the same cycle.
                if (inst == SYSCALL_WORD) begin
                    result_d  = v0;
                    halt_pc_d = pc;
                    state_d   = ST_DONE;
                end else if (cycle_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered from next state so the core is frozen on the edge that ends the run.
    assign core_rst_d = (state_d != ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            cycle_q    <= '0;
            result_q   <= '0;
            halt_pc_q  <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cycle_q    <= cycle_d;
            result_q   <= result_d;
            halt_pc_q  <= halt_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            core_rst_q <= core_rst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (trace_we) begin
            trace_mem[wr_ptr_q] <= pc;
        end
    end

    // Newest entry sits just behind the write pointer; wraps naturally at a power-of-two depth.
    assign rd_addr = wr_ptr_q - IDX_W'(1) - trace_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_pc_q <= '0;
        end else begin
            trace_pc_q <= trace_mem[rd_addr];
        end
    end

    assign core_rst    = core_rst_q;
    assign state       = state_q;
    assign halted      = (state_q == ST_DONE);
    assign timed_out   = (state_q == ST_TIMEOUT);
    assign cycle_cnt   = cycle_q;
    assign result      = result_q;
    assign halt_pc     = halt_pc_q;
    assign trace_pc    = trace_pc_q;
    assign trace_count = count_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: a tiny behavioural core stub feeds pc/inst/v0
// from a program table; two monitors differ only in their timeout.
module tb_mips_run_monitor;

    localparam logic [31:0] NOP      = 32'h00000000;
    localparam logic [31:0] SYSCALL  = 32'h0000000C;
    localparam logic [31:0] ADDI_V0  = 32'h2002000A;  // addi $v0,$0,10
    localparam logic [31:0] BEQ_SELF = 32'h1000FFFF;  // beq $0,$0,-1

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [31:0] pc, inst, v0;
    logic [2:0]  trace_idx;

    logic        a_core_rst, a_halted, a_timed_out;
    logic [2:0]  a_state;
    logic [31:0] a_cycle_cnt, a_result, a_halt_pc, a_trace_pc;
    logic [3:0]  a_trace_count;

    logic        b_core_rst, b_halted, b_timed_out;
    logic [2:0]  b_state;
    logic [31:0] b_cycle_cnt, b_result, b_halt_pc, b_trace_pc;
    logic [3:0]  b_trace_count;

    logic [31:0] prog [16];
    int n_cmp = 0;
    int n_bad = 0;

    mips_run_monitor #(.TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .inst(inst), .v0(v0),
        .trace_idx(trace_idx), .core_rst(a_core_rst), .state(a_state),
        .halted(a_halted), .timed_out(a_timed_out), .cycle_cnt(a_cycle_cnt),
        .result(a_result), .halt_pc(a_halt_pc), .trace_pc(a_trace_pc),
        .trace_count(a_trace_count)
    );

    mips_run_monitor #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .inst(inst), .v0(v0),
        .trace_idx(trace_idx), .core_rst(b_core_rst), .state(b_state),
        .halted(b_halted), .timed_out(b_timed_out), .cycle_cnt(b_cycle_cnt),
        .result(b_result), .halt_pc(b_halt_pc), .trace_pc(b_trace_pc),
        .trace_count(b_trace_count)
    );

    // One clock of the core stub; returns 1 ns after the rising edge.
    task automatic tick();
        logic cr;
        cr = a_core_rst;
        @(posedge clk);
        #1;
        if (cr) begin
            pc = 32'd0;
            v0 = 32'd0;
        end else if (inst != BEQ_SELF) begin
            if (inst[31:26] == 6'b001000 && inst[20:16] == 5'd2)
                v0 = {{16{inst[15]}}, inst[15:0]};
            pc = pc + 32'd4;
        end
        inst = prog[pc[5:2]];
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_prog(input int kind);
        for (int i = 0; i < 16; i++) prog[i] = NOP;
        case (kind)
            1: begin prog[0] = ADDI_V0; prog[3] = SYSCALL; end
            2: prog[0] = BEQ_SELF;
            3: prog[3] = SYSCALL;
            default: prog[10] = SYSCALL;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ticks(2);
        n_cmp++; if (a_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d expected 0", a_state); end
        n_cmp++; if (a_core_rst !== 1'b1) begin n_bad++; $display("FAIL rst_core_rst: got %0b expected 1", a_core_rst); end
        n_cmp++; if (a_halted !== 1'b0 || a_timed_out !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got %0b%0b expected 00", a_halted, a_timed_out); end
        n_cmp++; if (a_cycle_cnt !== 32'd0 || a_trace_count !== 4'd0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", a_cycle_cnt, a_trace_count); end
        n_cmp++; if (a_result !== 32'd0 || a_halt_pc !== 32'd0 || a_trace_pc !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %0h/%0h/%0h expected 0/0/0", a_result, a_halt_pc, a_trace_pc); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_run();
        load_prog(1);
        pulse_start();
        n_cmp++; if (a_state !== 3'd1 || a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t1_hold0: got state %0d rst %0b expected 1/1", a_state, a_core_rst); end
        tick();
        n_cmp++; if (a_state !== 3'd1 || a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t1_hold1: got state %0d rst %0b expected 1/1", a_state, a_core_rst); end
        tick();
        n_cmp++; if (a_state !== 3'd2 || a_core_rst !== 1'b0) begin n_bad++; $display("FAIL t1_run: got state %0d rst %0b expected 2/0", a_state, a_core_rst); end
        ticks(3);
        n_cmp++; if (a_state !== 3'd2 || a_cycle_cnt !== 32'd3) begin n_bad++; $display("FAIL t1_mid: got state %0d cnt %0d expected 2/3", a_state, a_cycle_cnt); end
        tick();
        n_cmp++; if (a_halted !== 1'b1 || a_timed_out !== 1'b0) begin n_bad++; $display("FAIL t1_halted: got %0b%0b expected 10", a_halted, a_timed_out); end
        n_cmp++; if (a_result !== 32'd10) begin n_bad++; $display("FAIL t1_result: got %0d expected 10", a_result); end
        n_cmp++; if (a_halt_pc !== 32'h0000000C) begin n_bad++; $display("FAIL t1_halt_pc: got %0h expected c", a_halt_pc); end
        n_cmp++; if (a_cycle_cnt !== 32'd4 || a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t1_cnt_rst: got %0d/%0b expected 4/1", a_cycle_cnt, a_core_rst); end
        trace_idx = 3'd3;
        tick();
        n_cmp++; if (a_trace_pc !== 32'd0 || a_cycle_cnt !== 32'd4 || a_state !== 3'd3) begin n_bad++; $display("FAIL t1_hold_done: got pc %0h cnt %0d st %0d expected 0/4/3", a_trace_pc, a_cycle_cnt, a_state); end
        trace_idx = 3'd0;
    endtask

    task automatic test_timeout();
        load_prog(2);
        pulse_start();
        ticks(2);
        ticks(15);
        n_cmp++; if (a_state !== 3'd2 || a_cycle_cnt !== 32'd15) begin n_bad++; $display("FAIL t2_pre: got state %0d cnt %0d expected 2/15", a_state, a_cycle_cnt); end
        tick();
        n_cmp++; if (a_timed_out !== 1'b1 || a_halted !== 1'b0 || a_state !== 3'd4) begin n_bad++; $display("FAIL t2_flags: got to %0b h %0b st %0d expected 1/0/4", a_timed_out, a_halted, a_state); end
        n_cmp++; if (a_cycle_cnt !== 32'd16 || a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t2_cnt: got %0d/%0b expected 16/1", a_cycle_cnt, a_core_rst); end
        n_cmp++; if (b_timed_out !== 1'b1 || b_cycle_cnt !== 32'd4) begin n_bad++; $display("FAIL t2_b: got %0b/%0d expected 1/4", b_timed_out, b_cycle_cnt); end
    endtask

    task automatic test_simultaneous();
        load_prog(3);
        pulse_start();
        ticks(2);
        ticks(4);
        n_cmp++; if (b_state !== 3'd3 || b_halted !== 1'b1 || b_timed_out !== 1'b0) begin n_bad++; $display("FAIL t3_state: got st %0d h %0b to %0b expected 3/1/0", b_state, b_halted, b_timed_out); end
        n_cmp++; if (b_cycle_cnt !== 32'd4 || b_halt_pc !== 32'h0000000C) begin n_bad++; $display("FAIL t3_cnt_pc: got %0d/%0h expected 4/c", b_cycle_cnt, b_halt_pc); end
    endtask

    task automatic test_trace();
        load_prog(4);
        pulse_start();
        ticks(2);
        ticks(11);
        n_cmp++; if (a_halted !== 1'b1 || a_halt_pc !== 32'h28 || a_cycle_cnt !== 32'd11) begin n_bad++; $display("FAIL t4_done: got h %0b pc %0h cnt %0d expected 1/28/11", a_halted, a_halt_pc, a_cycle_cnt); end
        n_cmp++; if (a_trace_count !== 4'd8) begin n_bad++; $display("FAIL t4_count: got %0d expected 8", a_trace_count); end
        trace_idx = 3'd0;
        tick();
        n_cmp++; if (a_trace_pc !== 32'h28) begin n_bad++; $display("FAIL t4_idx0: got %0h expected 28", a_trace_pc); end
        trace_idx = 3'd7;
        #1;
        n_cmp++; if (a_trace_pc !== 32'h28) begin n_bad++; $display("FAIL t4_latency: got %0h expected 28", a_trace_pc); end
        tick();
        n_cmp++; if (a_trace_pc !== 32'h0C) begin n_bad++; $display("FAIL t4_idx7: got %0h expected c", a_trace_pc); end
        trace_idx = 3'd3;
        tick();
        n_cmp++; if (a_trace_pc !== 32'h1C) begin n_bad++; $display("FAIL t4_idx3: got %0h expected 1c", a_trace_pc); end
        trace_idx = 3'd0;
    endtask

    task automatic test_mid_reset();
        load_prog(1);
        pulse_start();
        ticks(4);
        rst = 1'b1;
        #1;
        n_cmp++; if (a_state !== 3'd0 || a_core_rst !== 1'b1 || a_halted !== 1'b0 || a_timed_out !== 1'b0) begin n_bad++; $display("FAIL t5_ctrl: got st %0d rst %0b h %0b to %0b expected 0/1/0/0", a_state, a_core_rst, a_halted, a_timed_out); end
        n_cmp++; if (a_cycle_cnt !== 32'd0 || a_trace_count !== 4'd0 || a_trace_pc !== 32'd0) begin n_bad++; $display("FAIL t5_counts: got %0d/%0d/%0h expected 0/0/0", a_cycle_cnt, a_trace_count, a_trace_pc); end
        #2;
        rst = 1'b0;
        tick();
        pulse_start();
        ticks(6);
        n_cmp++; if (a_halted !== 1'b1 || a_result !== 32'd10 || a_halt_pc !== 32'hC || a_cycle_cnt !== 32'd4) begin n_bad++; $display("FAIL t5_rerun: got h %0b r %0d pc %0h cnt %0d expected 1/10/c/4", a_halted, a_result, a_halt_pc, a_cycle_cnt); end
    endtask

    task automatic test_back_to_back();
        load_prog(1);
        pulse_start();
        ticks(2);
        pulse_start();
        n_cmp++; if (a_state !== 3'd2 || a_cycle_cnt !== 32'd1) begin n_bad++; $display("FAIL t6_ignore: got st %0d cnt %0d expected 2/1", a_state, a_cycle_cnt); end
        ticks(3);
        n_cmp++; if (a_halted !== 1'b1 || a_result !== 32'd10 || a_cycle_cnt !== 32'd4) begin n_bad++; $display("FAIL t6_first: got h %0b r %0d cnt %0d expected 1/10/4", a_halted, a_result, a_cycle_cnt); end
        pulse_start();
        n_cmp++; if (a_halted !== 1'b0 || a_cycle_cnt !== 32'd0 || a_state !== 3'd1 || a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t6_restart: got h %0b cnt %0d st %0d rst %0b expected 0/0/1/1", a_halted, a_cycle_cnt, a_state, a_core_rst); end
        tick();
        n_cmp++; if (a_core_rst !== 1'b1) begin n_bad++; $display("FAIL t6_hold2: got %0b expected 1", a_core_rst); end
        tick();
        n_cmp++; if (a_core_rst !== 1'b0 || a_state !== 3'd2) begin n_bad++; $display("FAIL t6_release: got rst %0b st %0d expected 0/2", a_core_rst, a_state); end
        ticks(4);
        n_cmp++; if (a_halted !== 1'b1 || a_result !== 32'd10 || a_halt_pc !== 32'hC || a_cycle_cnt !== 32'd4) begin n_bad++; $display("FAIL t6_second: got h %0b r %0d pc %0h cnt %0d expected 1/10/c/4", a_halted, a_result, a_halt_pc, a_cycle_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pc = 32'd0;
        inst = 32'd0;
        v0 = 32'd0;
        trace_idx = 3'd0;
        for (int i = 0; i < 16; i++) prog[i] = NOP;
        #2;
        test_reset();
        test_basic_run();
        test_timeout();
        test_simultaneous();
        test_trace();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
